// File: rtl/voice_pkg.sv
// Shared definitions for the voice scheduler.
//
// Holds the voice count and datapath widths, the scheduler FSM encoding and
// a helper that locates a voice's field inside the packed per-voice address
// buses (voice_start / voice_end).
package voice_pkg;

   localparam int NVOICES = 8;
   localparam int ADDR_W  = 24;
   localparam int DATA_W  = 8;
   localparam int VIDX_W  = $clog2(NVOICES);
   localparam int MIX_W   = DATA_W + VIDX_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      FETCH = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Low bit of voice v's address field in a packed NVOICES*ADDR_W bus
   function automatic int slice_lo(input int v);
      return v * ADDR_W;
   endfunction

endpackage

// File: rtl/voice_state.sv
// Per-voice playback state.
//
// Holds the pending-trigger flag, the playing flag, the current read address
// and the inclusive end address of one voice.
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   trigger      one-cycle trigger strobe from the register file
//   load         scheduler accepted a sample tick; a pending trigger is applied
//   start_addr   start address copied into cur_addr on load
//   end_in       end address (inclusive) captured on load
//   advance      memory read for this voice completed
//   active       voice is playing
//   cur_addr     address of the next sample to fetch
module voice_state
   import voice_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              trigger,
   input  logic              load,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_in,
   input  logic              advance,
   output logic              active,
   output logic [ADDR_W-1:0] cur_addr
);

   logic              pending;
   logic [ADDR_W-1:0] end_addr;

   // A pending trigger (re)starts the voice from its start address, even if
   // it is already playing. After each completed read the voice either steps
   // to the next address or, having just read its end address, stops. The
   // ">=" test also stops a voice whose start lies beyond its end after one
   // sample, so cur_addr never runs past end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending  <= 1'b0;
         active   <= 1'b0;
         cur_addr <= '0;
         end_addr <= '0;
      end else begin
         if (load && pending) begin
            cur_addr <= start_addr;
            end_addr <= end_in;
            active   <= 1'b1;
         end else if (advance && active) begin
            if (cur_addr >= end_addr)
               active <= 1'b0;
            else
               cur_addr <= cur_addr + 1'b1;
         end

         // A trigger landing in the same cycle as the apply stays pending
         // for the following tick.
         if (trigger)
            pending <= 1'b1;
         else if (load)
            pending <= 1'b0;
      end
   end

endmodule

// File: rtl/voice_scheduler.sv
// Sample-playback scheduler for NVOICES voices sharing one memory read port.
//
// On every accepted sample tick, pending triggers are applied and the voices
// are visited in order 0..NVOICES-1. Each playing voice issues one read; its
// signed sample is added into the mix accumulator and its address advances.
// One mixed sample is produced per tick.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   sample_tick     one-cycle pulse at the sample rate
//   voice_start     packed per-voice start addresses (voice v at v*ADDR_W)
//   voice_end       packed per-voice inclusive end addresses
//   voice_trigger   per-voice one-cycle trigger strobes
//   mem_req         read request, held until mem_ack
//   mem_addr        read address, valid while mem_req=1
//   mem_ack         read complete, mem_data valid in the same cycle
//   mem_data        signed sample read from memory
//   mix_out         signed mix of all playing voices for the last tick
//   mix_valid       one-cycle pulse when mix_out updates
//   voice_active    per-voice playing flags
//   overrun         one-cycle pulse when a tick arrives while busy
module voice_scheduler
   import voice_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      sample_tick,
   input  logic [NVOICES*ADDR_W-1:0] voice_start,
   input  logic [NVOICES*ADDR_W-1:0] voice_end,
   input  logic [NVOICES-1:0]        voice_trigger,
   output logic                      mem_req,
   output logic [ADDR_W-1:0]         mem_addr,
   input  logic                      mem_ack,
   input  logic [DATA_W-1:0]         mem_data,
   output logic [MIX_W-1:0]          mix_out,
   output logic                      mix_valid,
   output logic [NVOICES-1:0]        voice_active,
   output logic                      overrun
);

   localparam logic [VIDX_W-1:0] LAST_V = VIDX_W'(NVOICES - 1);

   state_t              state;
   logic [VIDX_W-1:0]   vidx;
   logic [MIX_W-1:0]    acc;
   logic                accept;
   logic                last_voice;
   logic [NVOICES-1:0]  advance;
   logic [NVOICES-1:0]  active;
   logic [ADDR_W-1:0]   cur_addr [NVOICES];
   logic [MIX_W-1:0]    sample_ext;

   assign accept     = (state == IDLE) && sample_tick;
   assign last_voice = (vidx == LAST_V);
   assign sample_ext = {{(MIX_W - DATA_W){mem_data[DATA_W-1]}}, mem_data};
   assign voice_active = active;

   // One state block per voice. Only the voice currently being fetched sees
   // the acknowledge, and only while the scheduler is actually fetching.
   for (genvar v = 0; v < NVOICES; v++) begin : g_voice
      assign advance[v] = (state == FETCH) && mem_ack && (vidx == VIDX_W'(v));

      voice_state u_voice (
         .clk        (clk),
         .rst        (rst),
         .trigger    (voice_trigger[v]),
         .load       (accept),
         .start_addr (voice_start[slice_lo(v) +: ADDR_W]),
         .end_in     (voice_end[slice_lo(v) +: ADDR_W]),
         .advance    (advance[v]),
         .active     (active[v]),
         .cur_addr   (cur_addr[v])
      );
   end

   // Scheduler FSM. The memory request is registered on entry to FETCH so
   // address and request are stable for the whole handshake; it drops on the
   // edge that consumes the acknowledge. A tick that arrives outside IDLE is
   // dropped and flagged on overrun; triggers stay pending in the voices.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         vidx      <= '0;
         acc       <= '0;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         mix_out   <= '0;
         mix_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         mix_valid <= 1'b0;
         overrun   <= sample_tick && (state != IDLE);

         case (state)
            IDLE: begin
               if (sample_tick) begin
                  acc   <= '0;
                  vidx  <= '0;
                  state <= SCAN;
               end
            end

            SCAN: begin
               if (active[vidx]) begin
                  mem_req  <= 1'b1;
                  mem_addr <= cur_addr[vidx];
                  state    <= FETCH;
               end else if (last_voice) begin
                  state <= DONE;
               end else begin
                  vidx <= vidx + 1'b1;
               end
            end

            FETCH: begin
               if (mem_ack) begin
                  acc     <= acc + sample_ext;
                  mem_req <= 1'b0;
                  if (last_voice) begin
                     state <= DONE;
                  end else begin
                     vidx  <= vidx + 1'b1;
                     state <= SCAN;
                  end
               end
            end

            DONE: begin
               mix_out   <= acc;
               mix_valid <= 1'b1;
               state     <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed self-checking bench for voice_scheduler.
//
// The memory model answers address 0x01xx with 0x80, 0x07xx with 0x7F and
// anything else with the low address byte; the acknowledge follows mem_req
// combinationally while ack_en is set, so a read costs one cycle.
module tb_voice_scheduler;

   localparam int NV  = 8;
   localparam int AW  = 24;
   localparam int DW  = 8;
   localparam int MW  = 11;
   localparam int BOUND = 200;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              sample_tick = 1'b0;
   logic [NV*AW-1:0]  voice_start = '0;
   logic [NV*AW-1:0]  voice_end = '0;
   logic [NV-1:0]     voice_trigger = '0;
   logic              mem_req;
   logic [AW-1:0]     mem_addr;
   logic              mem_ack;
   logic [DW-1:0]     mem_data;
   logic [MW-1:0]     mix_out;
   logic              mix_valid;
   logic [NV-1:0]     voice_active;
   logic              overrun;

   logic              ack_en = 1'b1;
   logic [AW-1:0]     read_q[$];
   int                req_cycles = 0;
   int                checks = 0;
   int                failures = 0;

   voice_scheduler dut (
      .clk           (clk),
      .rst           (rst),
      .sample_tick   (sample_tick),
      .voice_start   (voice_start),
      .voice_end     (voice_end),
      .voice_trigger (voice_trigger),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ack       (mem_ack),
      .mem_data      (mem_data),
      .mix_out       (mix_out),
      .mix_valid     (mix_valid),
      .voice_active  (voice_active),
      .overrun       (overrun)
   );

   always #5 clk = ~clk;

   // Memory responder
   assign mem_ack = mem_req && ack_en;
   always_comb begin
      mem_data = mem_addr[7:0];
      if (mem_addr[15:8] == 8'h01) mem_data = 8'h80;
      else if (mem_addr[15:8] == 8'h07) mem_data = 8'h7F;
   end

   // Record completed reads and request cycles
   always @(posedge clk) begin
      if (!rst) begin
         if (mem_req) req_cycles <= req_cycles + 1;
         if (mem_req && mem_ack) read_q.push_back(mem_addr);
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL global_timeout: got running expected finished");
      $fatal(1, "[TB] timeout");
   end

   task automatic set_voice(input int v, input logic [AW-1:0] s, input logic [AW-1:0] e);
      voice_start[v*AW +: AW] = s;
      voice_end[v*AW +: AW]   = e;
   endtask

   task automatic clear_log();
      read_q.delete();
      req_cycles = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      sample_tick = 1'b0;
      voice_trigger = '0;
      ack_en = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_log();
   endtask

   task automatic pulse_trigger(input logic [NV-1:0] mask);
      @(negedge clk);
      voice_trigger = mask;
      @(negedge clk);
      voice_trigger = '0;
   endtask

   task automatic pulse_tick();
      @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
   endtask

   task automatic wait_mix(output int cycles);
      cycles = 0;
      while (!mix_valid && cycles < BOUND) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic wait_req(output int cycles);
      cycles = 0;
      while (!mem_req && cycles < BOUND) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   // Returns cycles from the tick cycle to the mix_valid cycle
   task automatic tick_and_wait(output int latency);
      int c;
      pulse_tick();
      wait_mix(c);
      latency = c + 1;
   endtask

   task automatic test_reset();
      int lat;
      @(negedge clk);
      checks++;
      if ({mem_req, mem_addr, mix_out, mix_valid, voice_active, overrun} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_values: got req=%0b addr=%0h mix=%0h mv=%0b act=%0h ovr=%0b expected all zero",
                  mem_req, mem_addr, mix_out, mix_valid, voice_active, overrun);
      end
      do_reset();
      tick_and_wait(lat);
      checks++;
      if (lat !== 10) begin
         failures++;
         $display("[TB] FAIL idle_latency: got %0d expected 10", lat);
      end
      checks++;
      if (mix_out !== 11'd0) begin
         failures++;
         $display("[TB] FAIL idle_mix: got %0h expected 0", mix_out);
      end
      checks++;
      if (req_cycles !== 0) begin
         failures++;
         $display("[TB] FAIL idle_no_req: got %0d expected 0", req_cycles);
      end
   endtask

   task automatic test_single_voice();
      int lat;
      logic [AW-1:0] a;
      do_reset();
      set_voice(2, 24'h000010, 24'h000012);
      pulse_trigger(8'h04);
      for (int t = 0; t < 3; t++) begin
         clear_log();
         tick_and_wait(lat);
         checks++;
         if (lat !== 11) begin
            failures++;
            $display("[TB] FAIL single_latency%0d: got %0d expected 11", t, lat);
         end
         checks++;
         if (mix_out !== MW'(16 + t)) begin
            failures++;
            $display("[TB] FAIL single_mix%0d: got %0d expected %0d", t, mix_out, 16 + t);
         end
         a = 24'h000010 + AW'(t);
         checks++;
         if (read_q.size() !== 1 || read_q[0] !== a) begin
            failures++;
            $display("[TB] FAIL single_read%0d: got n=%0d expected one read at %0h", t, read_q.size(), a);
         end
         checks++;
         if (voice_active !== ((t < 2) ? 8'h04 : 8'h00)) begin
            failures++;
            $display("[TB] FAIL single_active%0d: got %0h expected %0h", t, voice_active, (t < 2) ? 8'h04 : 8'h00);
         end
      end
      clear_log();
      tick_and_wait(lat);
      checks++;
      if (mix_out !== 11'd0 || lat !== 10 || req_cycles !== 0) begin
         failures++;
         $display("[TB] FAIL single_after_end: got mix=%0d lat=%0d reqs=%0d expected 0/10/0", mix_out, lat, req_cycles);
      end
   endtask

   task automatic test_mix_sign();
      int lat;
      do_reset();
      set_voice(0, 24'h000100, 24'h000100);
      set_voice(7, 24'h000700, 24'h000700);
      pulse_trigger(8'h81);
      tick_and_wait(lat);
      checks++;
      if (mix_out !== 11'h7FF) begin
         failures++;
         $display("[TB] FAIL mix_sign: got %0h expected 7ff", mix_out);
      end
      checks++;
      if (lat !== 12) begin
         failures++;
         $display("[TB] FAIL mix_latency: got %0d expected 12", lat);
      end
      checks++;
      if (read_q.size() !== 2 || read_q[0] !== 24'h000100 || read_q[1] !== 24'h000700) begin
         failures++;
         $display("[TB] FAIL mix_order: got n=%0d expected 100 then 700", read_q.size());
      end
      checks++;
      if (voice_active !== 8'h00) begin
         failures++;
         $display("[TB] FAIL mix_one_shot: got %0h expected 0", voice_active);
      end
   endtask

   task automatic test_start_past_end();
      int lat;
      do_reset();
      set_voice(1, 24'h000030, 24'h000005);
      pulse_trigger(8'h02);
      tick_and_wait(lat);
      checks++;
      if (mix_out !== 11'd48 || lat !== 11) begin
         failures++;
         $display("[TB] FAIL past_end_mix: got mix=%0d lat=%0d expected 48/11", mix_out, lat);
      end
      checks++;
      if (voice_active !== 8'h00) begin
         failures++;
         $display("[TB] FAIL past_end_stop: got %0h expected 0", voice_active);
      end
      clear_log();
      tick_and_wait(lat);
      checks++;
      if (mix_out !== 11'd0 || read_q.size() !== 0) begin
         failures++;
         $display("[TB] FAIL past_end_silent: got mix=%0d reads=%0d expected 0/0", mix_out, read_q.size());
      end
   endtask

   task automatic test_stall();
      int c;
      do_reset();
      set_voice(3, 24'h000042, 24'h000042);
      pulse_trigger(8'h08);
      ack_en = 1'b0;
      pulse_tick();
      wait_req(c);
      checks++;
      if (!mem_req) begin
         failures++;
         $display("[TB] FAIL stall_req_seen: got 0 expected 1");
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (mem_req !== 1'b1 || mem_addr !== 24'h000042 || mix_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stall_hold%0d: got req=%0b addr=%0h mv=%0b expected 1/42/0", i, mem_req, mem_addr, mix_valid);
         end
      end
      ack_en = 1'b1;
      wait_mix(c);
      checks++;
      if (mix_out !== 11'd66) begin
         failures++;
         $display("[TB] FAIL stall_mix: got %0d expected 66", mix_out);
      end
      checks++;
      if (read_q.size() !== 1) begin
         failures++;
         $display("[TB] FAIL stall_single_read: got %0d expected 1", read_q.size());
      end
   endtask

   task automatic test_overrun_retrigger();
      int c;
      int lat;
      do_reset();
      set_voice(0, 24'h000010, 24'h00001F);
      pulse_trigger(8'h01);
      ack_en = 1'b0;
      pulse_tick();
      wait_req(c);
      @(negedge clk);
      sample_tick = 1'b1;
      voice_trigger = 8'h01;
      @(negedge clk);
      sample_tick = 1'b0;
      voice_trigger = 8'h00;
      checks++;
      if (overrun !== 1'b1) begin
         failures++;
         $display("[TB] FAIL overrun_pulse: got %0b expected 1", overrun);
      end
      @(negedge clk);
      checks++;
      if (overrun !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 24'h000010) begin
         failures++;
         $display("[TB] FAIL overrun_no_restart: got ovr=%0b req=%0b addr=%0h expected 0/1/10", overrun, mem_req, mem_addr);
      end
      ack_en = 1'b1;
      wait_mix(c);
      checks++;
      if (mix_out !== 11'd16) begin
         failures++;
         $display("[TB] FAIL overrun_mix: got %0d expected 16", mix_out);
      end
      c = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (mix_valid) c++;
      end
      checks++;
      if (c !== 0) begin
         failures++;
         $display("[TB] FAIL overrun_dropped: got %0d extra mixes expected 0", c);
      end
      clear_log();
      tick_and_wait(lat);
      checks++;
      if (read_q.size() !== 1 || read_q[0] !== 24'h000010 || mix_out !== 11'd16) begin
         failures++;
         $display("[TB] FAIL retrigger_restart: got mix=%0d reads=%0d expected 16 from 10", mix_out, read_q.size());
      end
      tick_and_wait(lat);
      checks++;
      if (mix_out !== 11'd17 || lat !== 11) begin
         failures++;
         $display("[TB] FAIL retrigger_next: got mix=%0d lat=%0d expected 17/11", mix_out, lat);
      end
   endtask

   task automatic test_async_reset();
      int c;
      int lat;
      ack_en = 1'b0;
      pulse_tick();
      wait_req(c);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (mem_req !== 1'b0) begin
         failures++;
         $display("[TB] FAIL async_req_drop: got %0b expected 0", mem_req);
      end
      checks++;
      if ({mem_addr, mix_out, mix_valid, voice_active, overrun} !== '0) begin
         failures++;
         $display("[TB] FAIL async_outputs: got addr=%0h mix=%0h mv=%0b act=%0h ovr=%0b expected all zero",
                  mem_addr, mix_out, mix_valid, voice_active, overrun);
      end
      @(negedge clk);
      rst = 1'b0;
      ack_en = 1'b1;
      clear_log();
      tick_and_wait(lat);
      checks++;
      if (lat !== 10 || mix_out !== 11'd0 || read_q.size() !== 0) begin
         failures++;
         $display("[TB] FAIL async_clean_restart: got lat=%0d mix=%0d reads=%0d expected 10/0/0", lat, mix_out, read_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_voice();
      test_mix_sign();
      test_start_past_end();
      test_stall();
      test_overrun_retrigger();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/voice_scheduler.md
Name: voice_scheduler

Overview:
- Sequences sample playback for NVOICES voices that share one sample-memory read port.
- On each sample tick it applies pending voice triggers, then visits the voices in order 0..NVOICES-1. Each active voice issues one memory read, its signed sample is added into a mix accumulator, and its address advances.
- Sits between the control register file (start/end addresses, trigger strobes) and the sample memory. Produces one mixed sample per tick.

Parameters:
- NVOICES, 8, number of voices.
- ADDR_W, 24, sample address width (3 bytes per address).
- DATA_W, 8, sample width, signed two's complement.
- MIX_W, DATA_W+$clog2(NVOICES), mix accumulator/output width (11 at defaults).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sample_tick  in  1  one-cycle pulse at the sample rate.
- voice_start  in  NVOICES*ADDR_W  per-voice start address; voice v occupies bits [v*ADDR_W +: ADDR_W].
- voice_end  in  NVOICES*ADDR_W  per-voice end address, inclusive, same packing.
- voice_trigger  in  NVOICES  one-cycle trigger strobes, one per voice.
- mem_req  out  1  read request.
- mem_addr  out  ADDR_W  read address; valid while mem_req=1.
- mem_ack  in  1  read complete; mem_data is valid in the same cycle.
- mem_data  in  DATA_W  read data.
- mix_out  out  MIX_W  signed mixed sample.
- mix_valid  out  1  one-cycle pulse when mix_out updates.
- voice_active  out  NVOICES  per-voice playing flags.
- overrun  out  1  one-cycle pulse when a sample_tick arrives while the scheduler is busy.

Behaviour:
- Reset values: mem_req=0, mem_addr=0, mix_out=0, mix_valid=0, voice_active=0, overrun=0. Pending triggers, per-voice address and end registers, and the accumulator are also cleared; FSM goes to IDLE.
- Reset asserted mid-fetch drops mem_req immediately.
- Trigger latch: voice_trigger[v]=1 sets pending[v], in any state.
  - pending[v] is cleared only when it is applied.
  - If a new trigger arrives in the same cycle it is applied, pending[v] stays set.
- FSM states: IDLE, SCAN, FETCH, DONE.
- IDLE, on sample_tick:
  - For every v with pending[v]=1: cur_addr[v]<=voice_start[v], end_addr[v]<=voice_end[v], active[v]<=1, pending[v]<=0.
  - Retriggering a voice that is already active restarts it from its start address.
  - acc<=0, v<=0, go to SCAN.
- SCAN:
  - If active[v]: go to FETCH.
  - Else if v==NVOICES-1: go to DONE.
  - Else v<=v+1, stay in SCAN.
  - Voices activated in IDLE this tick are fetched this tick.
- FETCH:
  - Drive mem_req=1, mem_addr=cur_addr[v]. Hold both stable until mem_ack; no timeout.
  - On mem_ack:
    - acc<=acc+sign_extend(mem_data).
    - If cur_addr[v]>=end_addr[v]: active[v]<=0. Otherwise cur_addr[v]<=cur_addr[v]+1.
    - Deassert mem_req the next cycle.
    - Go to DONE if v==NVOICES-1, else v<=v+1 and go to SCAN.
  - mem_ack outside FETCH is ignored.
- DONE: mix_out<=acc, mix_valid=1 for one cycle, go to IDLE.
  - With no voices active, mix_out=0 is still emitted each tick.
- Latency: tick to mix_valid = 2 + (SCAN cycles) + sum of fetch times.
  - With all voices idle this is NVOICES+2 cycles.
- Boundaries:
  - The end address is inclusive.
  - start>end plays exactly one sample (at start), then the voice stops.
  - start==end plays one sample.
  - cur_addr never wraps past end.
  - A tick outside IDLE is dropped and overrun pulses for 1 cycle. Pending triggers are kept for the next accepted tick.
  - The accumulator cannot overflow, because MIX_W holds the sum of NVOICES extreme values.
- voice_active reflects active[] directly.

Decomposition:
- Shared package voice_pkg holds:
  - constants NVOICES, ADDR_W, DATA_W, MIX_W;
  - FSM state encoding (IDLE=0, SCAN=1, FETCH=2, DONE=3);
  - a function for the voice-slice index.
- One sub-module, voice_state, instantiated NVOICES times.
  - It holds pending, active, cur_addr and end_addr for one voice.
  - Its inputs are load (apply trigger), advance (ack for this voice) and trigger.
- The top level contains the FSM, the voice index, the accumulator and the memory mux.

Test Plan:
1. Reset idle: rst pulse, then tick. Required: mem_req stays 0, mix_valid pulses with mix_out=0, and it arrives exactly 10 cycles after the tick.
2. Single voice: voice 2 start=0x000010, end=0x000012; trigger[2]; zero-wait memory returns data=addr[7:0]. Required:
   - ticks 1–3 read 0x10, 0x11, 0x12 and give mix_out 16, 17, 18;
   - voice_active[2] drops after the 3rd read;
   - tick 4 gives 0 and issues no request.
3. Mix and sign: voices 0 and 7 triggered together, memory returns 0x80 for v0 and 0x7F for v7. Required: mix_out=-1; reads occur in order v0 then v7.
4. Handshake stall: mem_ack withheld for 5 cycles. Required: mem_req and mem_addr stay stable throughout; the accumulator updates only on the ack cycle.
5. Overrun/retrigger: a tick during FETCH gives an overrun pulse and no restart. Then trigger[0] during playback; at the next tick voice 0 reads from its start address again.
6. Async reset mid-FETCH: mem_req falls with no clock edge; all outputs take their reset values.
